dcr_write_queue: RTL and testbench

Buffers host DCR write requests and issues them, one at a time and at a controlled pace, onto the DCR write bus that feeds the base-DCR register file. It sits directly upstream of that register file, between the host MMIO/AFU command path and the `dcr_bus_if` write channel. It filters addresses outside the base-DCR window and keeps a saturating count of the writes it drops.

---
 rtl/dcr_write_queue_if.sv | 24 ++
 rtl/dcr_write_queue.sv | 64 ++++++
 tb/tb_dcr_write_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dcr_write_queue_if.sv
// dcr_write_queue_if: host write-request channel plus the DCR write strobe bus.
// The master is the host side; the slave is the queue that owns req_ready and the strobe.
interface dcr_write_queue_if #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 32
);
    logic                 req_valid;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_data;
    logic                 req_ready;
    logic                 dcr_write_valid;
    logic [ADDR_BITS-1:0] dcr_write_addr;
    logic [DATA_BITS-1:0] dcr_write_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data
    );
endinterface

// File: rtl/dcr_write_queue.sv
// dcr_write_queue: buffers host DCR writes and issues them one per strobe, paced by GAP,
// dropping addresses outside [ADDR_MIN, ADDR_MAX) with a saturating drop counter.
module dcr_write_queue #(
    parameter int                   DEPTH     = 4,
    parameter int                   ADDR_BITS = 12,
    parameter int                   DATA_BITS = 32,
    parameter int                   GAP       = 0,
    parameter logic [ADDR_BITS-1:0] ADDR_MIN  = ADDR_BITS'(1),
    parameter logic [ADDR_BITS-1:0] ADDR_MAX  = ADDR_BITS'(6)
) (
    input  logic             clk,
    input  logic             reset_n,
    dcr_write_queue_if.slave bus,
    input  logic             clear_drop,
    output logic             pending,
    output logic [7:0]       drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDR_BITS + DATA_BITS;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [3:0]    gap_cnt;
    logic          fire, in_range, push, pop;

    // count never exceeds DEPTH, so its top bit alone flags full
    assign bus.req_ready       = reset_n && !count[PW];
    assign fire                = bus.req_valid && bus.req_ready;
    assign in_range            = bus.req_addr >= ADDR_MIN && bus.req_addr < ADDR_MAX;
    assign push                = fire && in_range;
    assign pop                 = count != '0 && gap_cnt == '0;
    assign bus.dcr_write_valid = state == ISSUE;
    assign pending             = count != '0 || state == ISSUE;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {bus.req_addr, bus.req_data};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            gap_cnt            <= '0;
            drop_count         <= '0;
            bus.dcr_write_addr <= '0;
            bus.dcr_write_data <= '0;
        end else begin
            state   <= pop ? ISSUE : IDLE;
            wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count   <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
            gap_cnt <= pop ? 4'(GAP) : gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt;
            // clear wins over a coincident drop
            drop_count <= clear_drop ? '0
                        : fire && !in_range && drop_count != 8'hff ? drop_count + 8'd1
                        : drop_count;
            if (pop) {bus.dcr_write_addr, bus.dcr_write_data} <= mem[rd_ptr];
        end
endmodule

// File: tb/tb_dcr_write_queue.sv
// tb_dcr_write_queue: directed bench with one GAP=0 and one GAP=3 instance sharing clock and reset.
module tb_dcr_write_queue;
    localparam int         AB   = 12;
    localparam int         DB   = 32;
    localparam logic [11:0] AMIN = 12'h001;
    localparam logic [11:0] AMAX = 12'h006;

    logic       clk = 0, rst_n = 1, clr0 = 0, clr3 = 0;
    logic       pend0, pend3;
    logic [7:0] drop0, drop3;
    int         checks = 0, errors = 0, cyc = 0;

    logic [31:0] s0_data[$], s3_data[$];
    logic [11:0] s0_addr[$];
    int          s3_cyc[$];

    dcr_write_queue_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus0 ();
    dcr_write_queue_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus3 ();

    dcr_write_queue #(.DEPTH(4), .ADDR_BITS(AB), .DATA_BITS(DB), .GAP(0), .ADDR_MIN(AMIN), .ADDR_MAX(AMAX)) dut0 (
        .clk(clk), .reset_n(rst_n), .bus(bus0), .clear_drop(clr0), .pending(pend0), .drop_count(drop0));
    dcr_write_queue #(.DEPTH(4), .ADDR_BITS(AB), .DATA_BITS(DB), .GAP(3), .ADDR_MIN(AMIN), .ADDR_MAX(AMAX)) dut3 (
        .clk(clk), .reset_n(rst_n), .bus(bus3), .clear_drop(clr3), .pending(pend3), .drop_count(drop3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.dcr_write_valid) begin
            s0_data.push_back(bus0.dcr_write_data);
            s0_addr.push_back(bus0.dcr_write_addr);
        end
        if (bus3.dcr_write_valid) begin
            s3_data.push_back(bus3.dcr_write_data);
            s3_cyc.push_back(cyc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus0.req_valid = 1; bus0.req_addr = AMIN; bus0.req_data = 32'h1;
        bus3.req_valid = 1; bus3.req_addr = AMIN; bus3.req_data = 32'h1;
        #2 rst_n = 0;
        repeat (3) begin
            tick;
            checks++; if (bus0.req_ready !== 1'b0 || bus3.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0/0", bus0.req_ready, bus3.req_ready); end
            checks++; if (bus0.dcr_write_valid !== 1'b0 || bus3.dcr_write_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", bus0.dcr_write_valid, bus3.dcr_write_valid); end
            checks++; if (bus0.dcr_write_addr !== 12'h0 || bus0.dcr_write_data !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus0.dcr_write_addr, bus0.dcr_write_data); end
            checks++; if (pend0 !== 1'b0 || pend3 !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b/%b expected 0/0", pend0, pend3); end
            checks++; if (drop0 !== 8'd0 || drop3 !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d/%0d expected 0/0", drop0, drop3); end
        end
        bus0.req_valid = 0; bus3.req_valid = 0;
        @(negedge clk) rst_n = 1;
        tick;
        checks++; if (bus0.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b/%b expected 1/1", bus0.req_ready, bus3.req_ready); end
        s0_data.delete(); s0_addr.delete(); s3_data.delete(); s3_cyc.delete();
    endtask

    task automatic test_single_write;
        bus0.req_valid = 1; bus0.req_addr = 12'h001; bus0.req_data = 32'h8000_0000;
        tick;
        bus0.req_valid = 0;
        checks++; if (bus0.dcr_write_valid !== 1'b0 || pend0 !== 1'b1) begin errors++; $display("FAIL single_e0: got valid %b pending %b expected 0 1", bus0.dcr_write_valid, pend0); end
        tick;
        checks++; if (bus0.dcr_write_valid !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", bus0.dcr_write_valid); end
        checks++; if (bus0.dcr_write_addr !== 12'h001 || bus0.dcr_write_data !== 32'h8000_0000) begin errors++; $display("FAIL single_payload: got %h/%h expected 001/80000000", bus0.dcr_write_addr, bus0.dcr_write_data); end
        tick;
        checks++; if (bus0.dcr_write_valid !== 1'b0 || pend0 !== 1'b0) begin errors++; $display("FAIL single_after: got valid %b pending %b expected 0 0", bus0.dcr_write_valid, pend0); end
        checks++; if (bus0.dcr_write_addr !== 12'h001 || bus0.dcr_write_data !== 32'h8000_0000) begin errors++; $display("FAIL single_hold: got %h/%h expected 001/80000000", bus0.dcr_write_addr, bus0.dcr_write_data); end
        repeat (3) tick;
        checks++; if (s0_data.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", s0_data.size()); end
    endtask

    task automatic test_burst_to_full;
        logic exp_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic rp;
        int   i = 0, n = 0;
        s3_data.delete(); s3_cyc.delete();
        bus3.req_valid = 1; bus3.req_addr = 12'h002; bus3.req_data = 32'd1;
        while (i < 6 && n < 40) begin
            rp = bus3.req_ready;
            tick;
            if (rp) begin i++; bus3.req_data = 32'(i + 1); end
            if (n < 7) begin
                checks++; if (bus3.req_ready !== exp_rdy[n]) begin errors++; $display("FAIL burst_ready_e%0d: got %b expected %b", n, bus3.req_ready, exp_rdy[n]); end
            end
            n++;
        end
        bus3.req_valid = 0;
        checks++; if (i != 6) begin errors++; $display("FAIL burst_accepted: got %0d expected 6", i); end
        n = 0;
        while (s3_data.size() < 6 && n < 40) begin tick; n++; end
        repeat (8) tick;
        checks++; if (s3_data.size() !== 6) begin errors++; $display("FAIL burst_strobes: got %0d expected 6", s3_data.size()); end
        for (int k = 0; k < 6 && k < s3_data.size(); k++) begin
            checks++; if (s3_data[k] !== 32'(k + 1)) begin errors++; $display("FAIL burst_data%0d: got %0d expected %0d", k, s3_data[k], k + 1); end
            if (k > 0) begin
                checks++; if (s3_cyc[k] - s3_cyc[k-1] != 4) begin errors++; $display("FAIL burst_spacing%0d: got %0d expected 4", k, s3_cyc[k] - s3_cyc[k-1]); end
            end
        end
        checks++; if (pend3 !== 1'b0) begin errors++; $display("FAIL burst_pending: got %b expected 0", pend3); end
    endtask

    task automatic test_drops;
        s0_data.delete(); s0_addr.delete();
        bus0.req_valid = 1; bus0.req_addr = AMAX; bus0.req_data = 32'hdead;
        tick;
        checks++; if (drop0 !== 8'd1) begin errors++; $display("FAIL drop_max: got %0d expected 1", drop0); end
        bus0.req_addr = AMIN - 12'd1;
        tick;
        checks++; if (drop0 !== 8'd2) begin errors++; $display("FAIL drop_min: got %0d expected 2", drop0); end
        bus0.req_valid = 0;
        repeat (3) tick;
        checks++; if (s0_data.size() !== 0 || pend0 !== 1'b0) begin errors++; $display("FAIL drop_no_strobe: got %0d strobes pending %b expected 0 0", s0_data.size(), pend0); end
        bus0.req_valid = 1; bus0.req_addr = 12'h000;
        repeat (300) tick;
        checks++; if (drop0 !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop0); end
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b expected 1", bus0.req_ready); end
        clr0 = 1; bus0.req_addr = AMAX;
        tick;
        checks++; if (drop0 !== 8'd0) begin errors++; $display("FAIL drop_clear_prio: got %0d expected 0", drop0); end
        clr0 = 0;
        tick;
        checks++; if (drop0 !== 8'd1) begin errors++; $display("FAIL drop_after_clear: got %0d expected 1", drop0); end
        bus0.req_valid = 0;
        tick;
        checks++; if (drop0 !== 8'd1) begin errors++; $display("FAIL drop_hold: got %0d expected 1", drop0); end
    endtask

    int occ, max_occ;

    task automatic wtick(input logic acc);
        tick;
        if (acc) occ++;
        if (bus0.dcr_write_valid) occ--;
        if (occ > max_occ) max_occ = occ;
    endtask

    task automatic test_wrap_around;
        logic [31:0] exp_data[$];
        logic [11:0] exp_addr[$];
        logic        rp, done;
        int          n;
        s0_data.delete(); s0_addr.delete();
        occ = 0; max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ((i * 5) % 3) begin bus0.req_valid = 0; wtick(1'b0); end
            bus0.req_addr  = (i % 7 == 6) ? AMAX : 12'(1 + i % 5);
            bus0.req_data  = 32'hA000_0000 + 32'(i);
            bus0.req_valid = 1;
            done = 0; n = 0;
            while (!done && n < 20) begin
                rp = bus0.req_ready;
                if (rp && bus0.req_addr < AMAX) begin exp_data.push_back(bus0.req_data); exp_addr.push_back(bus0.req_addr); end
                wtick(rp && bus0.req_addr < AMAX);
                done = rp; n++;
            end
            checks++; if (!done) begin errors++; $display("FAIL wrap_accept%0d: got not accepted expected accepted", i); end
        end
        bus0.req_valid = 0;
        n = 0;
        while (pend0 !== 1'b0 && n < 30) begin wtick(1'b0); n++; end
        tick;
        checks++; if (s0_data.size() !== exp_data.size()) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", s0_data.size(), exp_data.size()); end
        for (int k = 0; k < exp_data.size() && k < s0_data.size(); k++) begin
            checks++; if (s0_data[k] !== exp_data[k] || s0_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL wrap_entry%0d: got %h/%h expected %h/%h", k, s0_addr[k], s0_data[k], exp_addr[k], exp_data[k]); end
        end
        checks++; if (max_occ > 4 || occ != 0) begin errors++; $display("FAIL wrap_occupancy: got max %0d final %0d expected <=4 and 0", max_occ, occ); end
        checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL wrap_pending: got %b expected 0", pend0); end
    endtask

    task automatic test_reset_mid_burst;
        logic rp;
        int   i = 0, n = 0;
        bus3.req_valid = 1; bus3.req_addr = 12'h003; bus3.req_data = 32'h100;
        while (i < 5 && n < 20) begin
            rp = bus3.req_ready;
            tick;
            if (rp) begin i++; bus3.req_data = 32'h100 + 32'(i); end
            n++;
        end
        bus3.req_valid = 0;
        n = 0;
        while (bus3.dcr_write_valid !== 1'b1 && n < 20) begin tick; n++; end
        checks++; if (bus3.dcr_write_valid !== 1'b1 || pend3 !== 1'b1) begin errors++; $display("FAIL mid_setup: got valid %b pending %b expected 1 1", bus3.dcr_write_valid, pend3); end
        #2 rst_n = 0;
        #1;
        checks++; if (bus3.dcr_write_valid !== 1'b0) begin errors++; $display("FAIL mid_cut: got %b expected 0", bus3.dcr_write_valid); end
        checks++; if (pend3 !== 1'b0 || bus3.req_ready !== 1'b0 || bus3.dcr_write_addr !== 12'h0) begin errors++; $display("FAIL mid_reset_state: got pending %b ready %b addr %h expected 0 0 000", pend3, bus3.req_ready, bus3.dcr_write_addr); end
        #3 rst_n = 1;
        s3_data.delete(); s3_cyc.delete();
        repeat (20) tick;
        checks++; if (s3_data.size() !== 0) begin errors++; $display("FAIL mid_stale: got %0d strobes expected 0", s3_data.size()); end
        checks++; if (pend3 !== 1'b0 || bus3.req_ready !== 1'b1) begin errors++; $display("FAIL mid_after: got pending %b ready %b expected 0 1", pend3, bus3.req_ready); end
    endtask

    initial begin
        bus0.req_valid = 0; bus0.req_addr = '0; bus0.req_data = '0;
        bus3.req_valid = 0; bus3.req_addr = '0; bus3.req_data = '0;
        test_reset;
        test_single_write;
        test_burst_to_full;
        test_drops;
        test_wrap_around;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
